// File: rtl/uart_rx_hex_display_if.sv
// Signal bundle between the UART line / display banks and uart_rx_hex_display.
// slave = receiver side (consumes the serial line), master = board/bench side.
interface uart_rx_hex_display_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    serial_data;
  logic [7:0]              rx_byte;
  logic                    rx_dv;
  logic                    frame_err;
  logic                    parity_err;
  logic [7*NUM_DIGITS-1:0] seg;

  modport slave (
    input  serial_data,
    output rx_byte,
    output rx_dv,
    output frame_err,
    output parity_err,
    output seg
  );

  modport master (
    output serial_data,
    input  rx_byte,
    input  rx_dv,
    input  frame_err,
    input  parity_err,
    input  seg
  );
endinterface

// File: rtl/uart_rx_hex_display.sv
// UART receiver (8N1, or 8E1 when UART_PARITY_EN is defined) feeding a byte history that
// drives NUM_DIGITS active-low hex seven-segment digits; the newest byte sits in digits 1..0.
module uart_rx_hex_display #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_DIGITS   = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  uart_rx_hex_display_if.slave  io_rx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned HW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop,
    StCleanup
  } state_e;

  state_e              r_state, w_state_next;
  logic                r_sync1, r_sync2;
  logic [CW-1:0]       r_count, w_count_next;
  logic [2:0]          r_bit_idx, w_bit_idx_next;
  logic [7:0]          r_data, w_data_next;
  logic [7:0]          r_rx_byte, w_rx_byte_next;
  logic                r_rx_dv, w_rx_dv_next;
  logic                r_frame_err, w_frame_err_next;
  logic                w_parity_err_next;
  logic [HW-1:0]       r_hist, w_hist_next;
  logic [7*NUM_DIGITS-1:0] r_seg, w_seg_next;
  logic                w_line;
  logic                w_par_mismatch;

  assign w_line = r_sync2;

`ifdef UART_PARITY_EN
  logic r_par_bit, w_par_bit_next;
  logic r_parity_err;
  assign w_par_mismatch = r_par_bit != (^r_data);
`else
  assign w_par_mismatch = 1'b0;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= io_rx.serial_data;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_count_next      = (r_count == LAST) ? '0 : r_count + 1'b1;
    w_bit_idx_next    = r_bit_idx;
    w_data_next       = r_data;
    w_rx_byte_next    = r_rx_byte;
    w_rx_dv_next      = 1'b0;
    w_frame_err_next  = 1'b0;
    w_parity_err_next = 1'b0;
    w_hist_next       = r_hist;
`ifdef UART_PARITY_EN
    w_par_bit_next    = r_par_bit;
`endif
    case (r_state)
      StIdle: begin
        w_count_next = '0;
        if (!w_line) w_state_next = StStart;
      end
      StStart: begin
        if (r_count == HALF) begin
          w_count_next = '0;
          w_state_next = w_line ? StIdle : StData;
        end
      end
      StData: begin
        if (r_count == LAST) begin
          w_data_next[r_bit_idx] = w_line;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = 3'd0;
            w_count_next   = '0;
`ifdef UART_PARITY_EN
            w_state_next   = StParity;
`else
            w_state_next   = StStop;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (r_count == LAST) begin
          w_par_bit_next = w_line;
          w_count_next   = '0;
          w_state_next   = StStop;
        end
      end
`endif
      StStop: begin
        if (r_count == LAST) begin
          w_frame_err_next  = !w_line;
          w_parity_err_next = w_par_mismatch;
          if (w_line && !w_par_mismatch) begin
            w_rx_byte_next = r_data;
            w_rx_dv_next   = 1'b1;
            w_hist_next    = (r_hist << 8) | HW'(r_data);
          end
          w_count_next = '0;
          w_state_next = StCleanup;
        end
      end
      StCleanup: begin
        w_count_next = '0;
        w_state_next = StIdle;
      end
      default: begin
        w_count_next = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  // Digit k shows nibble k of the history; registered, so it trails the history by one cycle.
  always_comb begin
    w_seg_next = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      w_seg_next[7*k +: 7] = hex_to_seg(r_hist[4*k +: 4]);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_bit_idx   <= 3'd0;
      r_data      <= 8'h00;
      r_rx_byte   <= 8'h00;
      r_rx_dv     <= 1'b0;
      r_frame_err <= 1'b0;
      r_hist      <= '0;
      r_seg       <= {NUM_DIGITS{7'h40}};
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_bit_idx   <= w_bit_idx_next;
      r_data      <= w_data_next;
      r_rx_byte   <= w_rx_byte_next;
      r_rx_dv     <= w_rx_dv_next;
      r_frame_err <= w_frame_err_next;
      r_hist      <= w_hist_next;
      r_seg       <= w_seg_next;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bit    <= w_par_bit_next;
      r_parity_err <= w_parity_err_next;
    end
  end
  assign io_rx.parity_err = r_parity_err;
`else
  assign io_rx.parity_err = 1'b0;
`endif

  assign io_rx.rx_byte   = r_rx_byte;
  assign io_rx.rx_dv     = r_rx_dv;
  assign io_rx.frame_err = r_frame_err;
  assign io_rx.seg       = r_seg;

endmodule

// File: tb/tb_uart_rx_hex_display.sv
// Scoreboard bench for uart_rx_hex_display: directed frames push expected pulses into a queue,
// a negedge monitor pops and compares on every DV/error pulse.
module tb_uart_rx_hex_display;
  localparam int unsigned CPB = 4;
  localparam int unsigned ND  = 4;

  localparam logic [27:0] S_RST  = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] S_A5   = {7'h40, 7'h40, 7'h08, 7'h12};
  localparam logic [27:0] S_A53C = {7'h08, 7'h12, 7'h30, 7'h46};
  localparam logic [27:0] S_0F   = {7'h40, 7'h40, 7'h40, 7'h0E};
  localparam logic [27:0] S_0F01 = {7'h40, 7'h0E, 7'h40, 7'h79};
  localparam logic [27:0] S_01FF = {7'h40, 7'h79, 7'h0E, 7'h0E};
  localparam logic [27:0] S_0FFF = {7'h40, 7'h0E, 7'h0E, 7'h0E};
  localparam logic [27:0] S_FF00 = {7'h0E, 7'h0E, 7'h40, 7'h40};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_hex_display_if #(.NUM_DIGITS(ND)) rx_if ();

  uart_rx_hex_display #(
    .CLKS_PER_BIT(CPB),
    .NUM_DIGITS  (ND)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .io_rx(rx_if)
  );

  typedef struct {
    logic        dv;
    logic        fe;
    logic        pe;
    logic [7:0]  b;
    logic [27:0] seg_before;
    logic [27:0] seg_after;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          n_pulses = 0;
  int          p0;
  logic        seg_pending = 1'b0;
  logic [27:0] seg_exp_after;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic dv, input logic fe, input logic pe, input logic [7:0] b,
                      input logic [27:0] sb, input logic [27:0] sa);
    exp_t x;
    x.dv = dv; x.fe = fe; x.pe = pe; x.b = b; x.seg_before = sb; x.seg_after = sa;
    q.push_back(x);
  endtask

  task automatic hold(input logic v);
    rx_if.serial_data = v;
    repeat (CPB) @(negedge clk);
  endtask

  // bad_par inverts the even-parity bit (only transmitted in parity builds).
  task automatic send(input logic [7:0] b, input logic bad_par, input logic stop);
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(b[i]);
`ifdef UART_PARITY_EN
    hold((^b) ^ bad_par);
`else
    if (bad_par) hold(1'b1);
`endif
    hold(stop);
    hold(1'b1);
    hold(1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || seg_pending); i++) @(negedge clk);
    check("drain", q.size() + int'(seg_pending), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seg_pending = 1'b0;
    end else begin
      if (seg_pending) begin
        check("seg_after", {4'h0, rx_if.seg}, {4'h0, seg_exp_after});
        seg_pending = 1'b0;
      end
      if (rx_if.rx_dv || rx_if.frame_err || rx_if.parity_err) begin
        n_pulses++;
        if (q.size() == 0) begin
          check("unexpected_pulse", {29'd0, rx_if.rx_dv, rx_if.frame_err, rx_if.parity_err}, 0);
        end else begin
          e = q.pop_front();
          check("flags", {29'd0, rx_if.rx_dv, rx_if.frame_err, rx_if.parity_err},
                {29'd0, e.dv, e.fe, e.pe});
          check("rx_byte", {24'd0, rx_if.rx_byte}, {24'd0, e.b});
          check("seg_before", {4'h0, rx_if.seg}, {4'h0, e.seg_before});
          seg_exp_after = e.seg_after;
          seg_pending   = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rx_if.serial_data = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_seg", {4'h0, rx_if.seg}, {4'h0, S_RST});
    check("rst_byte", {24'd0, rx_if.rx_byte}, 0);
    check("rst_pulses", {29'd0, rx_if.rx_dv, rx_if.frame_err, rx_if.parity_err}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_seg", {4'h0, rx_if.seg}, {4'h0, S_RST});
    check("idle_byte", {24'd0, rx_if.rx_byte}, 0);
    check("idle_pulses", n_pulses, 0);

    push(1'b1, 1'b0, 1'b0, 8'hA5, S_RST, S_A5);
    send(8'hA5, 1'b0, 1'b1);
    drain();

    push(1'b1, 1'b0, 1'b0, 8'h3C, S_A5, S_A53C);
    send(8'h3C, 1'b0, 1'b1);
    drain();

    push(1'b0, 1'b1, 1'b0, 8'h3C, S_A53C, S_A53C);
    send(8'h7E, 1'b0, 1'b0);
    drain();
    check("fe_byte_hold", {24'd0, rx_if.rx_byte}, 32'h3C);
    check("fe_seg_hold", {4'h0, rx_if.seg}, {4'h0, S_A53C});

    p0 = n_pulses;
    rx_if.serial_data = 1'b0;
    @(negedge clk);
    rx_if.serial_data = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_pulses", n_pulses, p0);
    check("glitch_byte", {24'd0, rx_if.rx_byte}, 32'h3C);

    // Abort a frame part-way through with reset.
    hold(1'b0);
    hold(1'b1);
    hold(1'b1);
    rst = 1'b1;
    rx_if.serial_data = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_seg", {4'h0, rx_if.seg}, {4'h0, S_RST});
    check("midrst_byte", {24'd0, rx_if.rx_byte}, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("postrst_seg", {4'h0, rx_if.seg}, {4'h0, S_RST});

    push(1'b1, 1'b0, 1'b0, 8'h0F, S_RST, S_0F);
    send(8'h0F, 1'b0, 1'b1);
    drain();

`ifdef UART_PARITY_EN
    push(1'b0, 1'b0, 1'b1, 8'h0F, S_0F, S_0F);
    send(8'h01, 1'b1, 1'b1);
    drain();
    push(1'b1, 1'b0, 1'b0, 8'h01, S_0F, S_0F01);
    send(8'h01, 1'b0, 1'b1);
    drain();
    push(1'b1, 1'b0, 1'b0, 8'hFF, S_0F01, S_01FF);
    send(8'hFF, 1'b0, 1'b1);
    drain();
    push(1'b0, 1'b1, 1'b1, 8'hFF, S_01FF, S_01FF);
    send(8'h7E, 1'b1, 1'b0);
    drain();
    push(1'b1, 1'b0, 1'b0, 8'h00, S_01FF, S_FF00);
`else
    push(1'b1, 1'b0, 1'b0, 8'hFF, S_0F, S_0FFF);
    send(8'hFF, 1'b0, 1'b1);
    drain();
    push(1'b1, 1'b0, 1'b0, 8'h00, S_0FFF, S_FF00);
`endif
    send(8'h00, 1'b0, 1'b1);
    drain();
    check("final_byte", {24'd0, rx_if.rx_byte}, 0);
    check("final_seg", {4'h0, rx_if.seg}, {4'h0, S_FF00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
